crc_engine: RTL and testbench
=============================

CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- CRC_W, 8, CRC register width; legal range 4..32.
- DATA_W, 8, input beat width; legal range 1..64.
- POLY, 8'h07, generator polynomial, CRC_W bits, implicit top bit omitted.
- INIT, 8'h00, register value loaded at start of frame.
- XOROUT, 8'h00, value XORed into the final result.
- REFIN, 0, 1 = each beat processed LSB first; 0 = MSB first.
- REFOUT, 0, 1 = register bit-reversed before XOROUT.
- RESIDUE, 8'h00, raw-register value that indicates a good received frame.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, block can accept a beat.
- s_data, in, DATA_W, input beat.
- s_sof, in, 1, beat is the first of a frame.
- s_eof, in, 1, beat is the last of a frame.
- m_valid, out, 1, result valid.
- m_ready, in, 1, result consumed.
- crc_out, out, CRC_W, final CRC.
- crc_ok, out, 1, raw register equals RESIDUE (valid with m_valid).
- beat_cnt, out, 16, beats in the frame (valid with m_valid).
- frame_err, out, 1, one-cycle protocol-error pulse.

Function
REQ-003 A beat SHALL be accepted on a rising edge where s_valid && s_ready.
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE. s_ready SHALL be 1 in IDLE and RUN, and 0 in DONE.
REQ-005 Per-bit update (serial LFSR): fb = bit ^ crc[CRC_W-1]; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-006 All DATA_W bits of an accepted beat SHALL be applied in one cycle. Bit order SHALL be s_data[DATA_W-1] down to [0] when REFIN=0, and s_data[0] up to [DATA_W-1] when REFIN=1.
REQ-007 A beat accepted with s_sof=1 SHALL start from INIT, never from the current register; beat_cnt SHALL restart at 1.
REQ-008 State transitions:
- IDLE + accepted sof: go to RUN, or to DONE if eof is also set.
- IDLE + accepted beat without sof: beat is discarded, frame_err pulses, state stays IDLE.
REQ-009 RUN behaviour:
- Accepted beat without sof: updates the register and increments beat_cnt.
- eof on that beat: go to DONE.
- Accepted sof while in RUN: frame_err pulses, the old frame is abandoned, and the new frame starts per REQ-007 (sof+eof goes to DONE).
REQ-010 Result outputs:
- crc_out = (REFOUT ? bit-reverse(reg) : reg) ^ XOROUT.
- crc_ok = (reg == RESIDUE).
- Both, plus beat_cnt, SHALL be registered by the same edge that accepts the eof beat.
- m_valid SHALL rise on the cycle after that edge (latency 1).
REQ-011 m_valid, crc_out, crc_ok and beat_cnt SHALL hold stable in DONE until m_ready=1 on an edge. On that edge the block SHALL return to IDLE and clear m_valid; s_ready SHALL be 1 on the following cycle.
REQ-012 beat_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-013 s_valid while s_ready=0 SHALL have no effect. frame_err SHALL stay 0 in that case.
REQ-014 m_ready while m_valid=0 SHALL have no effect.

Reset
REQ-015 While reset_n=0, regardless of clk, the block SHALL hold:
- state = IDLE, register = INIT;
- m_valid=0, crc_out=0, crc_ok=0, beat_cnt=0, frame_err=0;
- s_ready=0 during reset, and 1 on the first cycle after deassertion.
REQ-016 Reset asserted mid-frame or in DONE SHALL discard all frame state; no m_valid SHALL follow.

Verification
REQ-017 Defaults; "123456789" (31..39 hex), sof on the first beat, eof on the last -> m_valid one cycle after eof, crc_out=8'hF4, beat_cnt=9.
REQ-018 Defaults; the same 9 bytes followed by 8'hF4 as a 10th eof beat -> crc_ok=1, crc_out=8'h00, beat_cnt=10.
REQ-019 CRC_W=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF, REFIN=REFOUT=1, DATA_W=8; "123456789" -> crc_out=32'hCBF43926. Same frame with CBF43926 appended LSB-first and RESIDUE=32'hC704DD7B -> crc_ok=1.
REQ-020 CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, DATA_W=16; beats 3132,3334,3536,3738 then 39xx cannot be used, so send "12345678" as 4 beats -> crc_out matches the bytewise DATA_W=8 run of the same bytes.
REQ-021 Protocol errors:
- Beat without sof in IDLE -> frame_err pulse, state stays IDLE.
- sof mid-frame -> frame_err pulse; the result equals a clean run of the second frame only.
- Hold m_ready=0 for 5 cycles after m_valid -> outputs stable and s_ready=0 throughout.
REQ-022 Assert reset_n=0 on beat 4 of a 9-beat frame, then release -> no m_valid. A fresh "123456789" frame then gives 8'hF4.

Source files
------------

// File: rtl/crc_engine.sv
// Framed CRC engine: consumes DATA_W-bit beats in a single cycle each, then holds
// the finished CRC, residue check and beat count until the consumer takes them.
module crc_engine #(
   parameter int unsigned       CRC_W   = 8,
   parameter int unsigned       DATA_W  = 8,
   parameter logic [CRC_W-1:0]  POLY    = CRC_W'(8'h07),
   parameter logic [CRC_W-1:0]  INIT    = '0,
   parameter logic [CRC_W-1:0]  XOROUT  = '0,
   parameter bit                REFIN   = 1'b0,
   parameter bit                REFOUT  = 1'b0,
   parameter logic [CRC_W-1:0]  RESIDUE = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sof,
   input  logic              s_eof,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_ok,
   output logic [15:0]       beat_cnt,
   output logic              frame_err
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [CRC_W-1:0]  crc_q, crc_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [CRC_W-1:0]  res_crc_q, res_crc_d;
   logic              res_ok_q, res_ok_d;
   logic [15:0]       res_cnt_q, res_cnt_d;
   logic              m_valid_q, m_valid_d;
   logic              err_q, err_d;

   logic              accept;
   logic [CRC_W-1:0]  crc_base, crc_upd;
   logic [15:0]       cnt_base, cnt_upd;

   // Serial LFSR unrolled across the whole beat.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                 input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] c;
      logic             b;
      logic             fb;
      c = crc_in;
      for (int i = 0; i < int'(DATA_W); i++) begin
         b  = REFIN ? data[i] : data[int'(DATA_W) - 1 - i];
         fb = b ^ c[CRC_W-1];
         c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] c);
      logic [CRC_W-1:0] r;
      for (int i = 0; i < int'(CRC_W); i++) begin
         r[i] = c[int'(CRC_W) - 1 - i];
      end
      return r;
   endfunction

   assign s_ready = reset_n && (state_q != StDone);
   assign accept  = s_valid && s_ready;

   // A sof beat always restarts from INIT, even mid-frame.
   assign crc_base = s_sof ? INIT : crc_q;
   assign crc_upd  = crc_step(crc_base, s_data);
   assign cnt_base = s_sof ? 16'd0 : cnt_q;
   assign cnt_upd  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      res_crc_d = res_crc_q;
      res_ok_d  = res_ok_q;
      res_cnt_d = res_cnt_q;
      m_valid_d = m_valid_q;
      err_d     = 1'b0;
      case (state_q)
         StIdle, StRun: begin
            if (accept) begin
               if (state_q == StIdle && !s_sof) begin
                  err_d = 1'b1;
               end else begin
                  err_d   = s_sof && (state_q == StRun);
                  crc_d   = crc_upd;
                  cnt_d   = cnt_upd;
                  state_d = StRun;
                  if (s_eof) begin
                     state_d   = StDone;
                     res_crc_d = (REFOUT ? bit_rev(crc_upd) : crc_upd) ^ XOROUT;
                     res_ok_d  = (crc_upd == RESIDUE);
                     res_cnt_d = cnt_upd;
                     m_valid_d = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            if (m_ready) begin
               state_d   = StIdle;
               m_valid_d = 1'b0;
               crc_d     = INIT;
               cnt_d     = 16'd0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         crc_q     <= INIT;
         cnt_q     <= 16'd0;
         res_crc_q <= '0;
         res_ok_q  <= 1'b0;
         res_cnt_q <= 16'd0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         res_crc_q <= res_crc_d;
         res_ok_q  <= res_ok_d;
         res_cnt_q <= res_cnt_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
      end
   end

   assign m_valid   = m_valid_q;
   assign crc_out   = res_crc_q;
   assign crc_ok    = res_ok_q;
   assign beat_cnt  = res_cnt_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CRC-8 defaults, CRC-32 (reflected) and a 16-bit-beat
// CRC-16 instance share one input stream; each checks only its own results.
module tb_crc_engine;

   logic        clk;
   logic        reset_n;
   logic        s_valid;
   logic [15:0] din;
   logic        s_sof;
   logic        s_eof;
   logic        m_ready;

   logic        rdy8, mv8, ok8, err8;
   logic [7:0]  crc8;
   logic [15:0] cnt8;
   logic        rdy32, mv32, ok32, err32;
   logic [31:0] crc32;
   logic [15:0] cnt32;
   logic        rdy16, mv16, ok16, err16;
   logic [15:0] crc16;
   logic [15:0] cnt16;

   int n_cmp = 0;
   int n_err = 0;

   crc_engine dut8 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy8), .s_data(din[7:0]),
      .s_sof(s_sof), .s_eof(s_eof), .m_valid(mv8), .m_ready(m_ready), .crc_out(crc8),
      .crc_ok(ok8), .beat_cnt(cnt8), .frame_err(err8)
   );

   crc_engine #(
      .CRC_W(32), .DATA_W(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
      .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(32'hC704DD7B)
   ) dut32 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy32), .s_data(din[7:0]),
      .s_sof(s_sof), .s_eof(s_eof), .m_valid(mv32), .m_ready(m_ready), .crc_out(crc32),
      .crc_ok(ok32), .beat_cnt(cnt32), .frame_err(err32)
   );

   crc_engine #(
      .CRC_W(16), .DATA_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
      .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(16'h0000)
   ) dut16 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy16), .s_data(din),
      .s_sof(s_sof), .s_eof(s_eof), .m_valid(mv16), .m_ready(m_ready), .crc_out(crc16),
      .crc_ok(ok16), .beat_cnt(cnt16), .frame_err(err16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not reach summary (got timeout, required finish)");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] data;
      logic        sof;
      logic        eof;
      logic        exp_err;
      logic        chk8;
      logic [7:0]  exp_crc8;
      logic        exp_ok8;
      logic        chk32;
      logic [31:0] exp_crc32;
      logic        exp_ok32;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [7:0] d, input logic sof, input logic eof,
                               input logic err, input logic c8, input logic [7:0] e8,
                               input logic o8, input logic c32, input logic [31:0] e32,
                               input logic o32, input logic [15:0] cnt);
      vec_t v;
      v.data = {8'h00, d}; v.sof = sof; v.eof = eof; v.exp_err = err;
      v.chk8 = c8; v.exp_crc8 = e8; v.exp_ok8 = o8;
      v.chk32 = c32; v.exp_crc32 = e32; v.exp_ok32 = o32; v.exp_cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic sof, input logic eof);
      din = d; s_sof = sof; s_eof = eof; s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
   endtask

   task automatic consume();
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      check("m_valid cleared", 64'(mv8), 64'd0);
      check("s_ready after take", 64'(rdy8), 64'd1);
   endtask

   // Byte-at-a-time CRC-16/CCITT reference (init FFFF, no reflection).
   function automatic logic [15:0] ref_crc16(input logic [63:0] msg);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         c = c ^ {msg[63 - 8*i -: 8], 8'h00};
         for (int k = 0; k < 8; k++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   logic [7:0] msg [9];
   logic [7:0] app32 [4];

   initial begin
      msg   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      app32 = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      reset_n = 1'b0; s_valid = 1'b0; din = '0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b0;

      // "123456789": CRC-8 F4, CRC-32 CBF43926.
      for (int i = 0; i < 9; i++)
         add(msg[i], i == 0, i == 8, 1'b0, i == 8, 8'hF4, 1'b0, i == 8, 32'hCBF43926, 1'b0, 9);
      // Same bytes plus F4: CRC-8 residue reached.
      for (int i = 0; i < 9; i++)
         add(msg[i], i == 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      add(8'hF4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 10);
      // Orphan beat in idle.
      add(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      // Abandoned frame, then a clean restart via a second sof.
      add(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      add(8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      for (int i = 0; i < 9; i++)
         add(msg[i], i == 0, i == 8, i == 0, i == 8, 8'hF4, 1'b0, i == 8, 32'hCBF43926, 1'b0, 9);
      // Single-beat frame (sof+eof from idle): CRC-8 of 0x31 is 0x97.
      add(8'h31, 1'b1, 1'b1, 1'b0, 1'b1, 8'h97, 1'b0, 1'b0, 0, 0, 1);
      // CRC-32 with its own value appended LSB first: residue and fixed output.
      for (int i = 0; i < 9; i++)
         add(msg[i], i == 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         add(app32[i], 1'b0, i == 3, 1'b0, 1'b0, 0, 0, i == 3, 32'h2144DF1C, 1'b1, 13);

      // Reset values while held in reset with the clock running.
      #12;
      check("rst s_ready", 64'(rdy8), 64'd0);
      check("rst m_valid", 64'(mv8), 64'd0);
      check("rst crc_out", 64'(crc8), 64'd0);
      check("rst crc_ok", 64'(ok8), 64'd0);
      check("rst beat_cnt", 64'(cnt8), 64'd0);
      check("rst frame_err", 64'(err8), 64'd0);
      check("rst crc32 out", 64'(crc32), 64'd0);
      #10;
      reset_n = 1'b1;
      #1;
      check("s_ready after release", 64'(rdy8), 64'd1);

      foreach (vecs[n]) begin
         send(vecs[n].data, vecs[n].sof, vecs[n].eof);
         check($sformatf("frame_err v%0d", n), 64'(err8), 64'(vecs[n].exp_err));
         if (vecs[n].eof) begin
            check($sformatf("m_valid v%0d", n), 64'(mv8), 64'd1);
            check($sformatf("s_ready done v%0d", n), 64'(rdy8), 64'd0);
            if (vecs[n].chk8) begin
               check($sformatf("crc8 v%0d", n), 64'(crc8), 64'(vecs[n].exp_crc8));
               check($sformatf("ok8 v%0d", n), 64'(ok8), 64'(vecs[n].exp_ok8));
               check($sformatf("cnt8 v%0d", n), 64'(cnt8), 64'(vecs[n].exp_cnt));
            end
            if (vecs[n].chk32) begin
               check($sformatf("crc32 v%0d", n), 64'(crc32), 64'(vecs[n].exp_crc32));
               check($sformatf("ok32 v%0d", n), 64'(ok32), 64'(vecs[n].exp_ok32));
               check($sformatf("cnt32 v%0d", n), 64'(cnt32), 64'(vecs[n].exp_cnt));
            end
            consume();
         end
      end

      // 16-bit beats "12345678" against a bytewise reference.
      send(16'h3132, 1'b1, 1'b0);
      send(16'h3334, 1'b0, 1'b0);
      send(16'h3536, 1'b0, 1'b0);
      send(16'h3738, 1'b0, 1'b1);
      check("m_valid16", 64'(mv16), 64'd1);
      check("crc16", 64'(crc16), 64'(ref_crc16(64'h3132333435363738)));
      check("cnt16", 64'(cnt16), 64'd4);
      consume();

      // Back-pressure: results hold, and beats offered in DONE are ignored.
      for (int i = 0; i < 9; i++) send({8'h00, msg[i]}, i == 0, i == 8);
      din = 16'h0099; s_sof = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold m_valid c%0d", k), 64'(mv8), 64'd1);
         check($sformatf("hold crc8 c%0d", k), 64'(crc8), 64'hF4);
         check($sformatf("hold cnt8 c%0d", k), 64'(cnt8), 64'd9);
         check($sformatf("hold s_ready c%0d", k), 64'(rdy8), 64'd0);
         check($sformatf("hold frame_err c%0d", k), 64'(err8), 64'd0);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0; s_sof = 1'b0;
      consume();
      consume();  // m_ready with no result pending changes nothing

      // Reset on beat 4 of a 9-beat frame.
      send(16'h0031, 1'b1, 1'b0);
      send(16'h0032, 1'b0, 1'b0);
      send(16'h0033, 1'b0, 1'b0);
      din = 16'h0034; s_valid = 1'b1; reset_n = 1'b0;
      #2;
      check("midrst s_ready", 64'(rdy8), 64'd0);
      check("midrst m_valid", 64'(mv8), 64'd0);
      check("midrst beat_cnt", 64'(cnt8), 64'd0);
      check("midrst crc_out", 64'(crc8), 64'd0);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-rst m_valid c%0d", k), 64'(mv8), 64'd0);
      end
      for (int i = 0; i < 9; i++) send({8'h00, msg[i]}, i == 0, i == 8);
      check("fresh m_valid", 64'(mv8), 64'd1);
      check("fresh crc8", 64'(crc8), 64'hF4);
      check("fresh cnt8", 64'(cnt8), 64'd9);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
